// File: rtl/regfile_fwd_multi_pkg.sv
// Shared definitions for the forwarding register file.
// Holds default widths/depths and the bypass stage indices
// (EX is the youngest stage, WB the oldest).
package regfile_fwd_multi_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;
  localparam int NFWD_DEF   = 3;
  localparam int CNT_W_DEF  = 32;

  // Bypass stage index: lower index = younger result = higher priority.
  typedef enum logic [1:0] {
    STAGE_EX  = 2'd0,
    STAGE_MEM = 2'd1,
    STAGE_WB  = 2'd2
  } stage_e;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

endpackage

// File: rtl/regfile_fwd_multi_if.sv
// Bus bundle between the ID stage pipeline control (master) and the
// forwarding register file (slave).
//  master drives: read addresses, architectural write port, bypass
//                 stages, HI/LO writes and bypass, mult/div handshake.
//  slave drives:  read data, forwarded HI/LO, stall and stall counter.
interface regfile_fwd_multi_if
  import regfile_fwd_multi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NFWD   = NFWD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic [NRD*ADDR_W-1:0]  raddr;
  logic [NRD*DATA_W-1:0]  rdata;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [DATA_W-1:0]      wdata;
  logic [NFWD-1:0]        fwd_we;
  logic [NFWD*ADDR_W-1:0] fwd_addr;
  logic [NFWD*DATA_W-1:0] fwd_data;
  logic [NFWD-1:0]        fwd_rdy;
  logic                   hi_we;
  logic                   lo_we;
  logic [DATA_W-1:0]      hi_i;
  logic [DATA_W-1:0]      lo_i;
  logic [NFWD-1:0]        fwd_hi_we;
  logic [NFWD-1:0]        fwd_lo_we;
  logic [NFWD*DATA_W-1:0] fwd_hi;
  logic [NFWD*DATA_W-1:0] fwd_lo;
  logic                   hilo_rd;
  logic                   md_issue;
  logic                   md_done;
  logic [DATA_W-1:0]      hi_out;
  logic [DATA_W-1:0]      lo_out;
  logic                   stall;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output raddr, we, waddr, wdata, fwd_we, fwd_addr, fwd_data, fwd_rdy,
           hi_we, lo_we, hi_i, lo_i, fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
           hilo_rd, md_issue, md_done,
    input  rdata, hi_out, lo_out, stall, stall_cnt
  );

  modport slave (
    input  raddr, we, waddr, wdata, fwd_we, fwd_addr, fwd_data, fwd_rdy,
           hi_we, lo_we, hi_i, lo_i, fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
           hilo_rd, md_issue, md_done,
    output rdata, hi_out, lo_out, stall, stall_cnt
  );

endinterface

// File: rtl/regfile_fwd_multi_chk.sv
// Protocol checks for the forwarding register file.
//  clk/rst      clock and synchronous reset
//  md_issue     mult/div accepted this cycle
//  md_pend      mult/div outstanding
//  stall        hazard output
//  stall_cnt    stall cycle counter
module regfile_fwd_multi_chk
  import regfile_fwd_multi_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  input logic             md_issue,
  input logic             md_pend,
  input logic             stall,
  input logic [CNT_W-1:0] stall_cnt
);

  // A new mult/div must not be issued while one is still outstanding.
  a_issue_while_pend: assert property (
    @(posedge clk) disable iff (rst) !(md_issue && md_pend)
  );

  // The counter advances by exactly one per stall cycle until saturated.
  a_cnt_step: assert property (
    @(posedge clk) disable iff (rst)
      (stall && !(&stall_cnt)) |=> (stall_cnt == $past(stall_cnt) + {{(CNT_W-1){1'b0}}, 1'b1})
  );

endmodule

// File: rtl/regfile_fwd_multi_fwd_sel.sv
// One GPR read-port priority mux.
//  raddr            read address of this port
//  fwd_we/addr/data/rdy  bypass stages, index 0 youngest
//  we/waddr/wdata   architectural write port (write-through source)
//  arr_data         array contents at raddr
//  data             selected read value
//  haz              selected bypass stage has no valid result yet (load-use)
module regfile_fwd_multi_fwd_sel
  import regfile_fwd_multi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NFWD   = NFWD_DEF
) (
  input  logic [ADDR_W-1:0]      raddr,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD*ADDR_W-1:0] fwd_addr,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  input  logic [NFWD-1:0]        fwd_rdy,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W-1:0]      arr_data,
  output logic [DATA_W-1:0]      data,
  output logic                   haz
);

  logic [NFWD-1:0]   match;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              hit_rdy;

  // Per-stage address match against this port.
  always_comb begin
    match = {NFWD{1'b0}};
    for (int k = 0; k < NFWD; k++) begin
      match[k] = fwd_we[k] && (fwd_addr[k*ADDR_W +: ADDR_W] == raddr);
    end
  end

  // Priority select: scanning from oldest to youngest lets the youngest
  // match overwrite, so the lowest index wins and older stages are ignored.
  always_comb begin
    hit      = 1'b0;
    hit_data = {DATA_W{1'b0}};
    hit_rdy  = 1'b1;
    for (int k = NFWD - 1; k >= 0; k--) begin
      hit      = match[k] ? 1'b1 : hit;
      hit_data = match[k] ? fwd_data[k*DATA_W +: DATA_W] : hit_data;
      hit_rdy  = match[k] ? fwd_rdy[k] : hit_rdy;
    end

    data = arr_data;
    haz  = 1'b0;
    if (raddr == {ADDR_W{1'b0}}) begin
      // r0 reads zero and never waits on a bypass stage.
      data = {DATA_W{1'b0}};
      haz  = 1'b0;
    end else if (hit) begin
      data = hit_data;
      haz  = ~hit_rdy;
    end else if (we && (waddr == raddr)) begin
      data = wdata;
      haz  = 1'b0;
    end else begin
      data = arr_data;
      haz  = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_fwd_multi.sv
// Multi-port GPR/HI/LO register file with an NFWD-deep bypass network.
//  clk, rst   clock, synchronous active-high reset
//  bus        slave side of regfile_fwd_multi_if:
//             NRD combinational GPR read ports with load-use detection,
//             architectural GPR/HI/LO writes, per-stage bypass inputs,
//             forwarded HI/LO, mult/div pending scoreboard, stall and
//             a saturating stall-cycle counter.
module regfile_fwd_multi
  import regfile_fwd_multi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NFWD   = NFWD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  regfile_fwd_multi_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]     gpr [DEPTH];
  logic [DATA_W-1:0]     hi_reg;
  logic [DATA_W-1:0]     lo_reg;
  logic                  md_pend;
  logic [CNT_W-1:0]      cnt;
  logic [NRD-1:0]        gpr_haz;
  logic [NRD*DATA_W-1:0] rdata_mux;
  logic [DATA_W-1:0]     hi_sel;
  logic [DATA_W-1:0]     lo_sel;
  logic                  fwd_hi_hit;
  logic                  fwd_lo_hit;
  logic [DATA_W-1:0]     fwd_hi_val;
  logic [DATA_W-1:0]     fwd_lo_val;
  logic                  stall_now;

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      regfile_fwd_multi_fwd_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NFWD   (NFWD)
      ) u_sel (
        .raddr    (bus.raddr[i*ADDR_W +: ADDR_W]),
        .fwd_we   (bus.fwd_we),
        .fwd_addr (bus.fwd_addr),
        .fwd_data (bus.fwd_data),
        .fwd_rdy  (bus.fwd_rdy),
        .we       (bus.we),
        .waddr    (bus.waddr),
        .wdata    (bus.wdata),
        .arr_data (gpr[bus.raddr[i*ADDR_W +: ADDR_W]]),
        .data     (rdata_mux[i*DATA_W +: DATA_W]),
        .haz      (gpr_haz[i])
      );
    end
  endgenerate

  // HI/LO forwarding: youngest writing stage, then architectural write, then register.
  always_comb begin
    fwd_hi_hit = 1'b0;
    fwd_lo_hit = 1'b0;
    fwd_hi_val = {DATA_W{1'b0}};
    fwd_lo_val = {DATA_W{1'b0}};
    for (int k = NFWD - 1; k >= 0; k--) begin
      fwd_hi_hit = bus.fwd_hi_we[k] ? 1'b1 : fwd_hi_hit;
      fwd_hi_val = bus.fwd_hi_we[k] ? bus.fwd_hi[k*DATA_W +: DATA_W] : fwd_hi_val;
      fwd_lo_hit = bus.fwd_lo_we[k] ? 1'b1 : fwd_lo_hit;
      fwd_lo_val = bus.fwd_lo_we[k] ? bus.fwd_lo[k*DATA_W +: DATA_W] : fwd_lo_val;
    end

    if (fwd_hi_hit) begin
      hi_sel = fwd_hi_val;
    end else if (bus.hi_we) begin
      hi_sel = bus.hi_i;
    end else begin
      hi_sel = hi_reg;
    end

    if (fwd_lo_hit) begin
      lo_sel = fwd_lo_val;
    end else if (bus.lo_we) begin
      lo_sel = bus.lo_i;
    end else begin
      lo_sel = lo_reg;
    end
  end

  // Hazard: load-use on any port, MFHI/MFLO behind a pending mult/div,
  // or a second mult/div arriving while one is outstanding.
  always_comb begin
    stall_now = (|gpr_haz) | (bus.hilo_rd & md_pend) | (bus.md_issue & md_pend);
  end

  // Architectural GPR array; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        gpr[j] <= {DATA_W{1'b0}};
      end
    end else if (bus.we && (bus.waddr != {ADDR_W{1'b0}})) begin
      gpr[bus.waddr] <= bus.wdata;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= {DATA_W{1'b0}};
      lo_reg <= {DATA_W{1'b0}};
    end else begin
      if (bus.hi_we) begin
        hi_reg <= bus.hi_i;
      end
      if (bus.lo_we) begin
        lo_reg <= bus.lo_i;
      end
    end
  end

  // Mult/div scoreboard; issue beats done so a back-to-back op stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_pend <= 1'b0;
    end else if (bus.md_issue) begin
      md_pend <= 1'b1;
    end else if (bus.md_done) begin
      md_pend <= 1'b0;
    end
  end

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (stall_now && !(&cnt)) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.rdata     = rdata_mux;
  assign bus.hi_out    = hi_sel;
  assign bus.lo_out    = lo_sel;
  assign bus.stall     = stall_now;
  assign bus.stall_cnt = cnt;

  regfile_fwd_multi_chk #(
    .CNT_W (CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .md_issue  (bus.md_issue),
    .md_pend   (md_pend),
    .stall     (stall_now),
    .stall_cnt (cnt)
  );

endmodule

// File: tb/tb_regfile_fwd_multi.sv
// Self-checking bench for regfile_fwd_multi: directed scenarios plus
// randomized traffic against a behavioural model of the register file.
module tb_regfile_fwd_multi;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NFWD   = 3;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CMAX   = (2 ** CNT_W) - 1;

  logic clk;
  logic rst;

  regfile_fwd_multi_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W)
  ) bus ();

  regfile_fwd_multi #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic [ADDR_W-1:0] ra   [NRD];
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              fwe  [NFWD];
  logic [ADDR_W-1:0] fa   [NFWD];
  logic [DATA_W-1:0] fd   [NFWD];
  logic              frdy [NFWD];
  logic              hi_we, lo_we;
  logic [DATA_W-1:0] hi_i, lo_i;
  logic              fhwe [NFWD];
  logic              flwe [NFWD];
  logic [DATA_W-1:0] fh   [NFWD];
  logic [DATA_W-1:0] fl   [NFWD];
  logic              hilo_rd, md_issue, md_done;

  // reference model state
  logic [DATA_W-1:0] m_gpr [DEPTH];
  logic [DATA_W-1:0] m_hi, m_lo;
  logic              m_pend;
  int                m_cnt;
  logic              e_stall;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd(input int i);
    return bus.rdata[i*DATA_W +: DATA_W];
  endfunction

  task automatic idle();
    for (int i = 0; i < NRD; i++) ra[i] = '0;
    we = 1'b0; wa = '0; wd = '0;
    for (int k = 0; k < NFWD; k++) begin
      fwe[k] = 1'b0; fa[k] = '0; fd[k] = '0; frdy[k] = 1'b1;
      fhwe[k] = 1'b0; flwe[k] = 1'b0; fh[k] = '0; fl[k] = '0;
    end
    hi_we = 1'b0; lo_we = 1'b0; hi_i = '0; lo_i = '0;
    hilo_rd = 1'b0; md_issue = 1'b0; md_done = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NRD; i++) bus.raddr[i*ADDR_W +: ADDR_W] = ra[i];
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    for (int k = 0; k < NFWD; k++) begin
      bus.fwd_we[k] = fwe[k];
      bus.fwd_addr[k*ADDR_W +: ADDR_W] = fa[k];
      bus.fwd_data[k*DATA_W +: DATA_W] = fd[k];
      bus.fwd_rdy[k] = frdy[k];
      bus.fwd_hi_we[k] = fhwe[k];
      bus.fwd_lo_we[k] = flwe[k];
      bus.fwd_hi[k*DATA_W +: DATA_W] = fh[k];
      bus.fwd_lo[k*DATA_W +: DATA_W] = fl[k];
    end
    bus.hi_we = hi_we; bus.lo_we = lo_we; bus.hi_i = hi_i; bus.lo_i = lo_i;
    bus.hilo_rd = hilo_rd; bus.md_issue = md_issue; bus.md_done = md_done;
  endtask

  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) m_gpr[j] = '0;
    m_hi = '0; m_lo = '0; m_pend = 1'b0; m_cnt = 0;
  endtask

  // Expected combinational outputs from the model, compared against the DUT.
  task automatic check_cycle();
    logic [DATA_W-1:0] ed;
    logic eh;
    logic hit;
    logic [DATA_W-1:0] eh_v, el_v;
    e_stall = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      hit = 1'b0; eh = 1'b0; ed = m_gpr[ra[i]];
      if (ra[i] == '0) begin
        ed = '0;
      end else begin
        for (int k = 0; k < NFWD; k++) begin
          if (!hit && fwe[k] && fa[k] == ra[i]) begin
            hit = 1'b1; ed = fd[k]; eh = !frdy[k];
          end
        end
        if (!hit && we && wa == ra[i]) ed = wd;
      end
      if (!eh) chk($sformatf("rdata%0d", i), rd(i), ed);
      e_stall = e_stall | eh;
    end
    eh_v = hi_we ? hi_i : m_hi;
    el_v = lo_we ? lo_i : m_lo;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fhwe[k]) eh_v = fh[k];
      if (flwe[k]) el_v = fl[k];
    end
    chk("hi_out", bus.hi_out, eh_v);
    chk("lo_out", bus.lo_out, el_v);
    e_stall = e_stall | (hilo_rd & m_pend) | (md_issue & m_pend);
    chk("stall", {31'd0, bus.stall}, {31'd0, e_stall});
    chk("stall_cnt", {28'd0, bus.stall_cnt}, m_cnt);
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      if (we && wa != '0) m_gpr[wa] = wd;
      if (hi_we) m_hi = hi_i;
      if (lo_we) m_lo = lo_i;
      if (md_issue) m_pend = 1'b1;
      else if (md_done) m_pend = 1'b0;
      if (e_stall && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic eval();
    drive();
    #2;
    check_cycle();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    drive();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    eval();
    tick();
    rst = 1'b0;

    // Reset contents: every register reads zero.
    for (int j = 0; j < DEPTH / 2; j++) begin
      ra[0] = ADDR_W'(2 * j); ra[1] = ADDR_W'(2 * j + 1);
      eval();
      chk("rst_rd0", rd(0), 32'd0);
      chk("rst_rd1", rd(1), 32'd0);
      tick();
    end
    chk("rst_stall_cnt", {28'd0, bus.stall_cnt}, 32'd0);
    we = 1'b1; wa = 5'd5; wd = 32'hA5A5A5A5; ra[0] = 5'd6; ra[1] = 5'd6;
    eval(); tick();
    idle(); ra[0] = 5'd5;
    eval();
    chk("r5_after_wr", rd(0), 32'hA5A5A5A5);
    tick();

    // Bypass priority down to write-through.
    idle();
    for (int k = 0; k < NFWD; k++) begin fwe[k] = 1'b1; fa[k] = 5'd3; fd[k] = DATA_W'(k + 1); end
    we = 1'b1; wa = 5'd3; wd = 32'd4; ra[0] = 5'd3;
    eval(); chk("prio_ex", rd(0), 32'd1);
    fwe[0] = 1'b0; eval(); chk("prio_mem", rd(0), 32'd2);
    fwe[1] = 1'b0; eval(); chk("prio_wb", rd(0), 32'd3);
    fwe[2] = 1'b0; eval(); chk("prio_wthru", rd(0), 32'd4);
    tick();

    // Load-use hazard; older ready stage must not hide it.
    idle();
    fwe[0] = 1'b1; fa[0] = 5'd7; fd[0] = 32'hCAFE0007; frdy[0] = 1'b0; ra[1] = 5'd7;
    eval();
    chk("lu_stall", {31'd0, bus.stall}, 32'd1);
    chk("lu_cnt0", {28'd0, bus.stall_cnt}, 32'd0);
    tick();
    fwe[1] = 1'b1; fa[1] = 5'd7; fd[1] = 32'h11; frdy[1] = 1'b1;
    eval();
    chk("lu_cnt1", {28'd0, bus.stall_cnt}, 32'd1);
    chk("lu_old_ignored", {31'd0, bus.stall}, 32'd1);
    tick();
    frdy[0] = 1'b1;
    eval();
    chk("lu_rdy_stall", {31'd0, bus.stall}, 32'd0);
    chk("lu_rdy_data", rd(1), 32'hCAFE0007);
    tick();

    // r0 ignores writes and bypass stages.
    idle();
    we = 1'b1; wa = 5'd0; wd = 32'h0000FFFF;
    for (int k = 0; k < NFWD; k++) begin fwe[k] = 1'b1; fa[k] = 5'd0; fd[k] = $urandom; frdy[k] = 1'b0; end
    eval();
    chk("r0_rd0", rd(0), 32'd0);
    chk("r0_rd1", rd(1), 32'd0);
    chk("r0_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    idle(); eval(); chk("r0_after", rd(0), 32'd0); tick();

    // Mult/div scoreboard.
    idle(); md_issue = 1'b1; eval(); tick();
    md_issue = 1'b0; hilo_rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      eval(); chk("md_pend_stall", {31'd0, bus.stall}, 32'd1); tick();
    end
    md_done = 1'b1; fhwe[2] = 1'b1; fh[2] = 32'h1234;
    eval(); chk("md_done_hi", bus.hi_out, 32'h1234); tick();
    md_done = 1'b0;
    eval();
    chk("md_clear_stall", {31'd0, bus.stall}, 32'd0);
    chk("md_clear_hi", bus.hi_out, 32'h1234);
    tick();
    idle(); md_issue = 1'b1; md_done = 1'b1; eval(); tick();
    md_issue = 1'b0; md_done = 1'b0; hilo_rd = 1'b1;
    eval(); chk("md_issue_done", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1; eval(); tick();
    rst = 1'b0; eval();
    chk("md_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("md_rst_cnt", {28'd0, bus.stall_cnt}, 32'd0);
    tick();

    // Counter saturation.
    idle(); fwe[0] = 1'b1; fa[0] = 5'd9; frdy[0] = 1'b0; ra[0] = 5'd9;
    for (int c = 0; c < 20; c++) begin eval(); tick(); end
    eval(); chk("sat_cnt", {28'd0, bus.stall_cnt}, 32'd15); tick();
    eval(); chk("sat_hold", {28'd0, bus.stall_cnt}, 32'd15); tick();
    rst = 1'b1; idle(); eval(); tick(); rst = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NRD; i++) ra[i] = ADDR_W'($urandom_range(0, 7));
      we = ($urandom_range(0, 1) == 0); wa = ADDR_W'($urandom_range(0, 7)); wd = $urandom;
      for (int k = 0; k < NFWD; k++) begin
        fwe[k] = ($urandom_range(0, 2) == 0); fa[k] = ADDR_W'($urandom_range(0, 7));
        fd[k] = $urandom; frdy[k] = ($urandom_range(0, 3) != 0);
        fhwe[k] = ($urandom_range(0, 3) == 0); flwe[k] = ($urandom_range(0, 3) == 0);
        fh[k] = $urandom; fl[k] = $urandom;
      end
      hi_we = ($urandom_range(0, 3) == 0); lo_we = ($urandom_range(0, 3) == 0);
      hi_i = $urandom; lo_i = $urandom;
      hilo_rd = ($urandom_range(0, 2) == 0);
      md_issue = !m_pend && ($urandom_range(0, 3) == 0);
      md_done = ($urandom_range(0, 4) == 0);
      eval();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
